// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two requesters (A: pipeline, B: long-latency
// unit) and the RegisterFile write port.
//   A_* / B_*     : valid/ready write requests (Ready driven by the arbiter)
//   RegWrite,
//   WriteRegister,
//   WriteData     : registered RegisterFile write port (driven by the arbiter)
// Modports: master = requester/RegisterFile side, slave = arbiter.
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              A_Valid;
  logic [ADDR_W-1:0] A_Addr;
  logic [DATA_W-1:0] A_Data;
  logic              A_Ready;
  logic              B_Valid;
  logic [ADDR_W-1:0] B_Addr;
  logic [DATA_W-1:0] B_Data;
  logic              B_Ready;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;

  modport master (
    output A_Valid, A_Addr, A_Data, B_Valid, B_Addr, B_Data,
    input  A_Ready, B_Ready, RegWrite, WriteRegister, WriteData
  );

  modport slave (
    input  A_Valid, A_Addr, A_Data, B_Valid, B_Addr, B_Data,
    output A_Ready, B_Ready, RegWrite, WriteRegister, WriteData
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single RegisterFile write port between
// requester A and requester B, with one registered output stage.
// Ports:
//   Clk            clock, rising edge
//   Reset          synchronous, active-high
//   wb             writeback bus (slave side): A/B requests, RF write port
//   ReadRegister1/2 mirrors of the RegisterFile read addresses
//   Busy1/2        a write to the matching read register is staged (comb.)
module regfile_write_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter bit          ZERO_DISCARD = 1'b1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  regfile_write_arbiter_if.slave   wb,
  input  logic [ADDR_W-1:0]        ReadRegister1,
  input  logic [ADDR_W-1:0]        ReadRegister2,
  output logic                     Busy1,
  output logic                     Busy2
);

  // Which requester was granted most recently; LAST_B gives A priority next.
  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_e;

  last_e             last_q, last_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              grant_a, grant_b;

  always_comb begin
    last_d     = last_q;
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;

    grant_a = !Reset && wb.A_Valid && (!wb.B_Valid || (last_q == LAST_B));
    grant_b = !Reset && wb.B_Valid && !grant_a;

    if (grant_a) begin
      last_d     = LAST_A;
      wreg_d     = wb.A_Addr;
      wdata_d    = wb.A_Data;
      regwrite_d = !(ZERO_DISCARD && (wb.A_Addr == '0));
    end else if (grant_b) begin
      last_d     = LAST_B;
      wreg_d     = wb.B_Addr;
      wdata_d    = wb.B_Data;
      regwrite_d = !(ZERO_DISCARD && (wb.B_Addr == '0));
    end

    wb.A_Ready = grant_a;
    wb.B_Ready = grant_b;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_q     <= LAST_B;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      last_q     <= last_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

  // A write staged the edge before Reset rises would otherwise commit at the
  // very edge that applies the reset; masking it here drops that write.
  assign wb.RegWrite      = regwrite_q & ~Reset;
  assign wb.WriteRegister = wreg_q;
  assign wb.WriteData     = wdata_q;

  assign Busy1 = wb.RegWrite && (wreg_q == ReadRegister1);
  assign Busy2 = wb.RegWrite && (wreg_q == ReadRegister2);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural RegisterFile.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rr1, rr2;
  logic        busy1, busy2;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] rf [32] = '{default: '0};

  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) wb ();

  regfile_write_arbiter #(
    .DATA_W(32),
    .ADDR_W(5),
    .ZERO_DISCARD(1'b1)
  ) dut (
    .Clk(clk),
    .Reset(rst),
    .wb(wb),
    .ReadRegister1(rr1),
    .ReadRegister2(rr2),
    .Busy1(busy1),
    .Busy2(busy2)
  );

  // RegisterFile stand-in: commits on the rising edge when RegWrite is high.
  always @(posedge clk) begin
    if (wb.RegWrite) rf[wb.WriteRegister] <= wb.WriteData;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_wr [4] = '{9, 10, 9, 10};
  int exp_wd [4] = '{1, 2, 3, 4};
  int a_d, b_d;
  logic exp_a;

  initial begin
    rst = 1'b1;
    rr1 = '0;
    rr2 = '0;
    wb.A_Valid = 1'b1; wb.A_Addr = 5'd3; wb.A_Data = 32'd11;
    wb.B_Valid = 1'b0; wb.B_Addr = '0;   wb.B_Data = '0;

    // 1: reset holds off grants, then A is granted on release
    repeat (2) begin
      tick();
      check("rst_a_ready", wb.A_Ready, 0);
      check("rst_regwrite", wb.RegWrite, 0);
      check("rst_wreg", wb.WriteRegister, 0);
      check("rst_wdata", wb.WriteData, 0);
    end
    rst = 1'b0;
    #1 check("rel_a_ready", wb.A_Ready, 1);
    tick();
    wb.A_Valid = 1'b0;
    check("rel_regwrite", wb.RegWrite, 1);
    check("rel_wreg", wb.WriteRegister, 3);
    check("rel_wdata", wb.WriteData, 11);

    // 2: A only, then idle cycle holds the last address/data
    wb.A_Valid = 1'b1; wb.A_Addr = 5'd8; wb.A_Data = 32'd42;
    #1;
    check("a_only_a_ready", wb.A_Ready, 1);
    check("a_only_b_ready", wb.B_Ready, 0);
    tick();
    wb.A_Valid = 1'b0;
    check("a_only_regwrite", wb.RegWrite, 1);
    check("a_only_wreg", wb.WriteRegister, 8);
    check("a_only_wdata", wb.WriteData, 42);
    tick();
    check("idle_regwrite", wb.RegWrite, 0);
    check("idle_wreg_hold", wb.WriteRegister, 8);
    check("idle_wdata_hold", wb.WriteData, 42);

    // B only, leaves B as most recent grant so A wins the next tie
    wb.B_Valid = 1'b1; wb.B_Addr = 5'd5; wb.B_Data = 32'd77;
    #1;
    check("b_only_b_ready", wb.B_Ready, 1);
    check("b_only_a_ready", wb.A_Ready, 0);
    tick();
    wb.B_Valid = 1'b0;
    check("b_only_regwrite", wb.RegWrite, 1);
    check("b_only_wreg", wb.WriteRegister, 5);
    check("b_only_wdata", wb.WriteData, 77);

    // 3: both valid for 4 cycles -> A,B,A,B, one write per cycle
    a_d = 1; b_d = 2;
    wb.A_Valid = 1'b1; wb.A_Addr = 5'd9;
    wb.B_Valid = 1'b1; wb.B_Addr = 5'd10;
    for (int i = 0; i < 4; i++) begin
      wb.A_Data = a_d;
      wb.B_Data = b_d;
      #1;
      exp_a = (i % 2 == 0);
      check("rr_a_ready", wb.A_Ready, exp_a);
      check("rr_b_ready", wb.B_Ready, !exp_a);
      tick();
      check("rr_regwrite", wb.RegWrite, 1);
      check("rr_wreg", wb.WriteRegister, exp_wr[i]);
      check("rr_wdata", wb.WriteData, exp_wd[i]);
      if (exp_a) a_d += 2; else b_d += 2;
    end
    wb.A_Valid = 1'b0;
    wb.B_Valid = 1'b0;

    // 4: same address from both; B granted second, its value lands last
    wb.A_Valid = 1'b1; wb.A_Addr = 5'd12; wb.A_Data = 32'd7;
    wb.B_Valid = 1'b1; wb.B_Addr = 5'd12; wb.B_Data = 32'd9;
    rr1 = 5'd12;
    #1;
    check("same_a_ready", wb.A_Ready, 1);
    check("same_b_wait", wb.B_Ready, 0);
    tick();
    wb.A_Valid = 1'b0;
    #1;
    check("same_wdata_a", wb.WriteData, 7);
    check("same_busy1_a", busy1, 1);
    check("same_b_ready", wb.B_Ready, 1);
    tick();
    wb.B_Valid = 1'b0;
    #1;
    check("same_wdata_b", wb.WriteData, 9);
    check("same_busy1_b", busy1, 1);
    tick();
    check("same_busy1_after", busy1, 0);
    check("same_rf_r12", rf[12], 9);

    // 5: write to r0 handshakes but is discarded
    rr1 = '0;
    rr2 = '0;
    wb.B_Valid = 1'b1; wb.B_Addr = 5'd0; wb.B_Data = 32'd55;
    #1 check("zero_b_ready", wb.B_Ready, 1);
    tick();
    wb.B_Valid = 1'b0;
    #1;
    check("zero_regwrite", wb.RegWrite, 0);
    check("zero_busy1", busy1, 0);
    check("zero_busy2", busy2, 0);
    tick();
    check("zero_rf_r0", rf[0], 0);

    // 6: reset right after a grant drops the staged write
    rr1 = 5'd20;
    wb.A_Valid = 1'b1; wb.A_Addr = 5'd20; wb.A_Data = 32'd99;
    #1 check("rstmid_a_ready", wb.A_Ready, 1);
    tick();
    wb.A_Valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rstmid_regwrite", wb.RegWrite, 0);
    check("rstmid_busy1", busy1, 0);
    tick();
    check("rstmid_rf_r20", rf[20], 0);
    rst = 1'b0;
    #1;
    check("rstmid_post_regwrite", wb.RegWrite, 0);
    check("rstmid_post_wreg", wb.WriteRegister, 0);
    tick();
    check("rstmid_idle_regwrite", wb.RegWrite, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
